// File: rtl/dm_main_mem_if.sv
// rtl/dm_main_mem_if.sv - cache/main-memory line request and response types plus the bus interface
package cache_definition;

    // Line request from the cache: 20-bit word address, 64-bit line of four 16-bit words
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [19:0] addr;
        logic [63:0] data;
    } cache_to_mem_type;

    // Line response to the cache: one-cycle ready pulse with the read line
    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } mem_to_cache_type;

endpackage

interface dm_main_mem_if;
    cache_definition::cache_to_mem_type cache_to_mem;
    cache_definition::mem_to_cache_type mem_to_cache;

    modport master (output cache_to_mem, input  mem_to_cache);
    modport slave  (input  cache_to_mem, output mem_to_cache);
endinterface

// File: rtl/dm_main_mem.sv
// rtl/dm_main_mem.sv - latency-programmable line-granular main memory behind the direct-mapped cache (optional stats: DM_MAIN_MEM_STATS_EN)
module dm_main_mem #(
    parameter int LATENCY = 4,   // 1..15; fits the 4-bit wait counter
    parameter int LINE_AW = 18
) (
    input  logic         clk,
    input  logic         rst,
    dm_main_mem_if.slave bus
`ifdef DM_MAIN_MEM_STATS_EN
    ,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 req_rw_q;
    logic [LINE_AW-1:0]   req_line_q;
    logic [63:0]          req_data_q;
    logic [63:0]          rdata_q;
    logic                 accept;
    logic                 access;

    logic [63:0]          mem_q [2**LINE_AW];

    // Word-select and high address bits do not take part in line selection
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.cache_to_mem.addr;

    // Next-state logic: accept in IDLE, count down in BUSY, one response cycle in RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cache_to_mem.valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; inputs are only looked at on the accepting edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_rw_q   <= 1'b0;
            req_line_q <= '0;
            req_data_q <= 64'h0;
        end else if (accept) begin
            req_rw_q   <= bus.cache_to_mem.rw;
            req_line_q <= bus.cache_to_mem.addr[LINE_AW+1:2];
            req_data_q <= bus.cache_to_mem.data;
        end
    end

    // Line storage; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (rst && access && req_rw_q) begin
            mem_q[req_line_q] <= req_data_q;
        end
    end

    // Response data register holds the last read line across later writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 64'h0;
        end else if (access && !req_rw_q) begin
            rdata_q <= mem_q[req_line_q];
        end
    end

    assign bus.mem_to_cache = '{ready: (state_q == RESP), data: rdata_q};

`ifdef DM_MAIN_MEM_STATS_EN
    // Completed-access counters, bumped on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else if (access) begin
            if (req_rw_q) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_main_mem.sv
// tb/tb_dm_main_mem.sv - directed self-checking bench for dm_main_mem
module tb_dm_main_mem;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    dm_main_mem_if bus ();

`ifdef DM_MAIN_MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    dm_main_mem #(.LATENCY(4), .LINE_AW(18)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave)
`ifdef DM_MAIN_MEM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request: accept, drop valid, wait for ready, leave RESP
    task automatic do_req(input logic rw, input logic [19:0] addr, input logic [63:0] data,
                          output int lat, output logic [63:0] rd, output logic low_after);
        bus.cache_to_mem = '{valid: 1'b1, rw: rw, addr: addr, data: data};
        tick();
        bus.cache_to_mem.valid = 1'b0;
        lat = 0;
        while (!bus.mem_to_cache.ready && lat < 20) begin
            tick();
            lat++;
        end
        rd = bus.mem_to_cache.data;
        tick();
        low_after = ~bus.mem_to_cache.ready;
    endtask

    int          lat;
    int          n;
    int          pulses;
    logic [63:0] rd;
    logic        low;

    initial begin
        checks = 0;
        errors = 0;
        bus.cache_to_mem = '{valid: 1'b0, rw: 1'b0, addr: 20'h0, data: 64'h0};

        // Reset then idle
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_to_cache.ready !== 1'b0 || bus.mem_to_cache.data !== 64'h0) n++;
        end
        check("idle_disturbed_cycles", 64'(n), 64'd0);
        check("reset_data", bus.mem_to_cache.data, 64'h0);

        // Write then read same line through a different word select
        do_req(1'b1, 20'h01234, 64'hDEAD_BEEF_0123_4567, lat, rd, low);
        check("wr_latency", 64'(lat), 64'd4);
        check("wr_ready_one_cycle", 64'(low), 64'd1);
        check("wr_keeps_data", rd, 64'h0);
        do_req(1'b0, 20'h01237, 64'h0, lat, rd, low);
        check("rd_latency", 64'(lat), 64'd4);
        check("rd_data", rd, 64'hDEAD_BEEF_0123_4567);
        check("rd_ready_one_cycle", 64'(low), 64'd1);

        // Write-back then allocate with valid held high
        do_req(1'b1, 20'h05004, 64'h1111_2222_3333_4444, lat, rd, low);
        bus.cache_to_mem = '{valid: 1'b1, rw: 1'b1, addr: 20'h0A004, data: 64'hAAAA_BBBB_CCCC_DDDD};
        tick();
        lat = 0;
        while (!bus.mem_to_cache.ready && lat < 20) begin
            tick();
            lat++;
        end
        check("chain_wb_latency", 64'(lat), 64'd4);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) begin
                bus.cache_to_mem.rw   = 1'b0;
                bus.cache_to_mem.addr = 20'h05004;
            end
        end while (!bus.mem_to_cache.ready && n < 20);
        bus.cache_to_mem.valid = 1'b0;
        check("chain_ready_spacing", 64'(n), 64'd6);
        check("chain_alloc_data", bus.mem_to_cache.data, 64'h1111_2222_3333_4444);
        tick();
        do_req(1'b0, 20'h0A006, 64'h0, lat, rd, low);
        check("chain_wb_committed", rd, 64'hAAAA_BBBB_CCCC_DDDD);

        // Input disturbance while busy
        bus.cache_to_mem = '{valid: 1'b1, rw: 1'b1, addr: 20'h00100, data: 64'h0F0F_F0F0_5555_AAAA};
        tick();
        pulses = 0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            bus.cache_to_mem = '{valid: 1'b0, rw: 1'(i), addr: 20'(i * 4), data: {$urandom, $urandom}};
            tick();
            if (bus.mem_to_cache.ready) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("disturb_pulses", 64'(pulses), 64'd1);
        check("disturb_latency", 64'(lat), 64'd4);
        do_req(1'b0, 20'h00101, 64'h0, lat, rd, low);
        check("disturb_data", rd, 64'h0F0F_F0F0_5555_AAAA);

        // Reset one cycle before a write commit
        do_req(1'b1, 20'h00800, 64'h0123_4567_89AB_CDEF, lat, rd, low);
        bus.cache_to_mem = '{valid: 1'b1, rw: 1'b1, addr: 20'h00800, data: 64'hFFFF_0000_FFFF_0000};
        tick();
        bus.cache_to_mem.valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_to_cache.ready) pulses++;
            tick();
        end
        check("abort_no_ready", 64'(pulses), 64'd0);
        check("abort_data_reset", bus.mem_to_cache.data, 64'h0);
        do_req(1'b0, 20'h00800, 64'h0, lat, rd, low);
        check("abort_old_contents", rd, 64'h0123_4567_89AB_CDEF);

        // Response data survives a later write
        do_req(1'b1, 20'h00100, 64'h7777_7777_7777_7777, lat, rd, low);
        check("data_held_over_write", bus.mem_to_cache.data, 64'h0123_4567_89AB_CDEF);

`ifdef DM_MAIN_MEM_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("stats_reset_rd", 64'(rd_count), 64'd0);
        do_req(1'b0, 20'h00100, 64'h0, lat, rd, low);
        do_req(1'b1, 20'h00200, 64'h2, lat, rd, low);
        do_req(1'b0, 20'h00200, 64'h0, lat, rd, low);
        do_req(1'b1, 20'h00300, 64'h3, lat, rd, low);
        do_req(1'b0, 20'h00300, 64'h0, lat, rd, low);
        check("stats_rd", 64'(rd_count), 64'd3);
        check("stats_wr", 64'(wr_count), 64'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("stats_rd_cleared", 64'(rd_count), 64'd0);
        check("stats_wr_cleared", 64'(wr_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_main_mem.md
# dm_main_mem

Backing main-memory model and controller sitting directly downstream of the direct-mapped cache controller. It consumes `cache_to_mem_type` line requests (64-bit line = four 16-bit words), services line reads for allocate and line writes for write-back after a programmable access latency, and returns `mem_to_cache_type` responses. It is synthesizable. It is also the memory endpoint for the cache testbench.

## Interface
- `LATENCY`, 4: wait cycles between request acceptance and response; legal range 1..15.
- `LINE_AW`, 18: line-address width; storage depth 2**LINE_AW lines × 64 bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `cache_to_mem`  in  struct  cache_definition::cache_to_mem_type, with fields `valid` (1), `rw` (1, 1 = write), `addr` (20, word address) and `data` (64, line).
- `mem_to_cache`  out  struct  cache_definition::mem_to_cache_type, with fields `ready` (1) and `data` (64).
- `rd_count`  out  32  completed line reads; present only with DM_MAIN_MEM_STATS_EN.
- `wr_count`  out  32  completed line writes; present only with DM_MAIN_MEM_STATS_EN.

## Operation
- Line index is `addr[LINE_AW+1:2]`. `addr[1:0]` (word select) and `addr[19:LINE_AW+2]` are ignored.
- FSM states:
  - IDLE: if `valid`=1, latch `rw`, line index and `data` into request registers, load the counter with LATENCY-1, and go to BUSY. If `valid`=0, stay in IDLE.
  - BUSY: decrement the counter each cycle.
    - When counter==0 on a write, store the latched data into the line.
    - When counter==0 on a read, load the line into the response-data register.
    - When counter==0, go to RESP.
  - RESP: `ready`=1 for exactly this one cycle, then go to IDLE unconditionally.
- `mem_to_cache.data` holds the last read line until the next read completes. Writes do not modify it.
- Inputs are sampled only in IDLE. Changes to `valid`, `rw`, `addr` or `data` during BUSY or RESP are ignored.
- If `valid` drops during BUSY, the latched request still completes and `ready` still pulses.
- A request presented during RESP is not accepted in RESP. It is accepted in the following IDLE cycle if `valid` is still high. This supports the cache's write_back→allocate sequence, where `valid` stays high and `rw` falls to 0.
- Only one request is outstanding at a time. There is no queueing.
- Storage contents are not reset; uninitialised lines read X in simulation.

## Timing
- Reset (`rst`=0 at a clock edge):
  - FSM goes to IDLE, counter to 0, `ready` to 0, `mem_to_cache.data` to 64'h0.
  - Statistics counters go to 0.
- Reset during BUSY aborts the request. A write whose commit edge has not occurred is not stored.
- Request accepted at edge T (IDLE, `valid`=1):
  - access occurs at edge T+LATENCY;
  - `ready`=1 in cycle T+LATENCY to T+LATENCY+1;
  - earliest next acceptance is edge T+LATENCY+2.
- Read data is valid in the same cycle `ready`=1. The data and `ready` are both registered, with no combinational path from input to output.
- Back-to-back throughput is one request per LATENCY+2 cycles.
- `ready` is never high for two consecutive cycles.

## Configuration
- Macro: `DM_MAIN_MEM_STATS_EN`.
- Defined:
  - `rd_count` and `wr_count` ports exist.
  - Each counter increments by 1 on the edge entering RESP for a read or write respectively.
  - Counters wrap from 32'hFFFF_FFFF to 0 and reset to 0.
- Undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset then idle: hold `rst`=0 for 2 cycles, release, keep `valid`=0 for 10 cycles → `ready`=0 and `data`=64'h0 throughout.
- Write then read, LATENCY=4: write addr 20'h01234 with data 64'hDEAD_BEEF_0123_4567. `ready` pulses 4 cycles after acceptance, for one cycle. Then read addr 20'h01237 → data 64'hDEAD_BEEF_0123_4567.
- Write-back→allocate chain: hold `valid`=1 and, in the cycle after `ready`, switch `rw` from 1 to 0 and addr from 20'h0A004 to 20'h05004 → write committed to line 0x2801, second `ready` 6 cycles after the first, returning the prior contents of line 0x1401.
- Input disturbance: after acceptance, drop `valid` and change addr/data every cycle during BUSY → the originally latched request completes unchanged with one `ready` pulse.
- Reset mid-write: assert `rst`=0 one cycle before the commit edge → `ready` never pulses, and a subsequent read of that line returns the old contents.
- Stats (macro defined): 3 reads and 2 writes → `rd_count`=3, `wr_count`=2. Then reset → both 0.
